bus_bridge_uart_req_framer: RTL and testbench

Remote-side UART framer that feeds the initiator UART link. It accepts one bus-bridge request on a valid/ready port and serializes it as a 4-byte request frame into a byte-level UART transmitter. It then collects the 2-byte response frame from the UART receiver and returns it on a valid/ready response port. Only one transaction is outstanding at a time. A response timeout guarantees forward progress if the link is dead.

---
 rtl/bus_bridge_uart_req_framer.sv | 185 ++++++++++++++++++
 tb/tb_bus_bridge_uart_req_framer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_bridge_uart_req_framer.sv
// Remote-side request framer for the bus-bridge UART link.
// Takes one request, sends it as a 4-byte frame through a byte-level UART
// transmitter, then collects the 2-byte response and hands it back.
// A response timeout produces an error response when the link goes quiet.
module bus_bridge_uart_req_framer #(
    parameter logic [31:0] RESP_TIMEOUT = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_is_write,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_rdata,
    output logic        resp_is_write,
    output logic        resp_err,
    output logic [7:0]  uart_data_in,
    output logic        uart_wr_en,
    input  logic        uart_tx_busy,
    input  logic        uart_ready,
    output logic        uart_ready_clr,
    input  logic [7:0]  uart_data_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_R0,
        WAIT_R1,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;
    logic        cap_is_write;
    logic [31:0] timeout_cnt;
    logic        tx_busy_d;
    logic        ready_q;

    logic        tx_done;
    logic        rx_pulse;
    logic        timeout_hit;
    logic [7:0]  tx_byte;

    // The transmitter finishing a byte shows up as busy falling; a new RX byte
    // shows up as the ready level rising.
    assign tx_done  = tx_busy_d && !uart_tx_busy;
    assign rx_pulse = uart_ready && !ready_q;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // A zero timeout value means wait forever for the response.
    assign timeout_hit = (RESP_TIMEOUT != 32'd0) &&
                         (timeout_cnt == (RESP_TIMEOUT - 32'd1));

    // Pick the frame byte for the current index: address low, address high,
    // write data, then the read/write flag.
    always_comb begin
        tx_byte = cap_addr[7:0];
        case (byte_idx)
            2'd0:    tx_byte = cap_addr[7:0];
            2'd1:    tx_byte = cap_addr[15:8];
            2'd2:    tx_byte = cap_wdata;
            default: tx_byte = {7'b0, cap_is_write};
        endcase
    end

    // Delayed copies of the UART status lines for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_d <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            tx_busy_d <= uart_tx_busy;
            ready_q   <= uart_ready;
        end
    end

    // Frame sequencer: send four bytes, collect two, present the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_idx       <= 2'd0;
            cap_addr       <= 16'd0;
            cap_wdata      <= 8'd0;
            cap_is_write   <= 1'b0;
            timeout_cnt    <= 32'd0;
            uart_data_in   <= 8'd0;
            uart_wr_en     <= 1'b0;
            uart_ready_clr <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 8'd0;
            resp_is_write  <= 1'b0;
            resp_err       <= 1'b0;
        end else begin
            uart_wr_en     <= 1'b0;
            // Every new RX byte is acknowledged, including stale ones that
            // arrive outside the response window and are simply dropped.
            uart_ready_clr <= rx_pulse;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        cap_is_write <= req_is_write;
                        byte_idx     <= 2'd0;
                        state        <= SEND;
                    end
                end

                SEND: begin
                    if (!uart_tx_busy) begin
                        uart_data_in <= tx_byte;
                        uart_wr_en   <= 1'b1;
                        state        <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (tx_done) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= SEND;
                        end else begin
                            timeout_cnt <= 32'd0;
                            state       <= WAIT_R0;
                        end
                    end
                end

                WAIT_R0: begin
                    if (rx_pulse) begin
                        resp_rdata  <= uart_data_out;
                        timeout_cnt <= 32'd0;
                        state       <= WAIT_R1;
                    end else if (timeout_hit) begin
                        resp_rdata    <= 8'd0;
                        resp_is_write <= cap_is_write;
                        resp_err      <= 1'b1;
                        resp_valid    <= 1'b1;
                        state         <= RESP;
                    end else if (timeout_cnt != 32'hFFFF_FFFF) begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end

                WAIT_R1: begin
                    if (rx_pulse) begin
                        resp_is_write <= uart_data_out[0];
                        resp_err      <= (uart_data_out[0] != cap_is_write);
                        resp_valid    <= 1'b1;
                        state         <= RESP;
                    end else if (timeout_hit) begin
                        resp_rdata    <= 8'd0;
                        resp_is_write <= cap_is_write;
                        resp_err      <= 1'b1;
                        resp_valid    <= 1'b1;
                        state         <= RESP;
                    end else if (timeout_cnt != 32'hFFFF_FFFF) begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge_uart_req_framer.sv
// Bench for the bus-bridge UART request framer: a UART TX/RX model around
// the DUT, a table of hand-derived transactions, corner-case sequences and
// randomized transactions checked against a behavioural response model.
module tb_bus_bridge_uart_req_framer;

    localparam logic [31:0] TO = 32'd100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_is_write;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_rdata;
    logic        resp_is_write;
    logic        resp_err;
    logic [7:0]  uart_data_in;
    logic        uart_wr_en;
    logic        uart_tx_busy;
    logic        uart_ready;
    logic        uart_ready_clr;
    logic [7:0]  uart_data_out;
    logic        busy;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        is_write;
        int          nrx;
        logic [7:0]  rx0;
        logic [7:0]  rx1;
        logic [7:0]  exp_rdata;
        logic        exp_is_write;
        logic        exp_err;
        int          hold;
        logic        stall;
    } vec_t;

    vec_t vecs[6];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] tx_log[$];
    int busy_left    = 0;
    int last_fall    = 0;
    int wr_busy_errs = 0;
    int stall_seq    = 0;
    int stall_seen   = 0;
    int stall_len    = 3;

    int   clr_count  = 0;
    int   rise_count = 0;
    int   rise_cyc   = 0;
    logic resp_prev  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bus_bridge_uart_req_framer #(.RESP_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_is_write   (req_is_write),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_is_write  (resp_is_write),
        .resp_err       (resp_err),
        .uart_data_in   (uart_data_in),
        .uart_wr_en     (uart_wr_en),
        .uart_tx_busy   (uart_tx_busy),
        .uart_ready     (uart_ready),
        .uart_ready_clr (uart_ready_clr),
        .uart_data_out  (uart_data_out),
        .busy           (busy)
    );

    // UART transmitter model: logs each byte started, stays busy a few cycles,
    // and can be told to look busy before a frame starts.
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                uart_tx_busy = 1'b0;
                busy_left    = 0;
                stall_seen   = stall_seq;
            end else if (uart_wr_en) begin
                if (uart_tx_busy) wr_busy_errs++;
                tx_log.push_back(uart_data_in);
                uart_tx_busy = 1'b1;
                busy_left    = $urandom_range(1, 4);
            end else if (stall_seq != stall_seen) begin
                stall_seen = stall_seq;
                if (!uart_tx_busy) begin
                    uart_tx_busy = 1'b1;
                    busy_left    = stall_len;
                end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    uart_tx_busy = 1'b0;
                    last_fall    = cyc;
                end
            end
        end
    end

    // Counts RX acknowledges and records when resp_valid rises.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_ready_clr) clr_count++;
            if (resp_valid && !resp_prev) begin
                rise_count++;
                rise_cyc = cyc;
            end
            resp_prev = resp_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] addr, input logic [7:0] wdata,
                                input logic w, input int nrx, input logic [7:0] rx0,
                                input logic [7:0] rx1, input logic [7:0] er,
                                input logic ew, input logic ee, input int hold,
                                input logic stall);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.is_write = w; v.nrx = nrx;
        v.rx0 = rx0; v.rx1 = rx1; v.exp_rdata = er; v.exp_is_write = ew;
        v.exp_err = ee; v.hold = hold; v.stall = stall;
        return v;
    endfunction

    // Response rules: two bytes give data plus echoed flag (error on flag
    // disagreement); fewer than two bytes end in a timeout error response.
    function automatic vec_t model_fill(input vec_t vin);
        vec_t v;
        v = vin;
        if (v.nrx >= 2) begin
            v.exp_rdata    = v.rx0;
            v.exp_is_write = v.rx1[0];
            v.exp_err      = (v.rx1[0] != v.is_write);
        end else begin
            v.exp_rdata    = 8'h00;
            v.exp_is_write = v.is_write;
            v.exp_err      = 1'b1;
        end
        return v;
    endfunction

    task automatic send_rx(input logic [7:0] b, output int set_cyc);
        uart_data_out = b;
        uart_ready    = 1'b1;
        set_cyc       = cyc;
        for (int i = 0; i < 8; i++) begin
            step();
            if (uart_ready_clr) break;
        end
        uart_ready = 1'b0;
        step();
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [7:0]  exp_frame[4];
        logic [31:0] act;
        int s, exp_edge, clr_base, rise_base, tx_base, bad, ok;
        exp_frame[0] = v.addr[7:0];
        exp_frame[1] = v.addr[15:8];
        exp_frame[2] = v.wdata;
        exp_frame[3] = {7'b0, v.is_write};
        tx_base   = tx_log.size();
        clr_base  = clr_count;
        rise_base = rise_count;

        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1; break; end
            step();
        end
        check({tag, ".req_ready_idle"}, ok, 1);

        req_addr = v.addr; req_wdata = v.wdata; req_is_write = v.is_write;
        req_valid = 1'b1;
        if (v.stall) begin
            stall_len = 3;
            stall_seq++;
        end
        step();
        req_valid = 1'b0;
        check({tag, ".req_ready_busy"}, req_ready, 0);
        check({tag, ".busy"}, busy, 1);

        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (tx_log.size() >= tx_base + 4 && !uart_tx_busy) begin ok = 1; break; end
            step();
        end
        check({tag, ".frame_done"}, ok, 1);
        step();
        check({tag, ".tx_count"}, tx_log.size() - tx_base, 4);
        for (int i = 0; i < 4; i++) begin
            act = (tx_base + i < tx_log.size()) ? 32'(tx_log[tx_base + i]) : 32'hDEAD;
            check($sformatf("%s.tx_byte%0d", tag, i), act, 32'(exp_frame[i]));
        end

        exp_edge = last_fall + 1 + int'(TO);
        if (v.nrx >= 1) begin
            repeat ($urandom_range(0, 4)) step();
            send_rx(v.rx0, s);
            exp_edge = s + 1 + int'(TO);
        end
        if (v.nrx >= 2) begin
            repeat ($urandom_range(0, 4)) step();
            send_rx(v.rx1, s);
            exp_edge = s + 1;
        end

        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (resp_valid) begin ok = 1; break; end
            step();
        end
        check({tag, ".resp_valid"}, ok, 1);
        check({tag, ".rdata"}, resp_rdata, v.exp_rdata);
        check({tag, ".is_write"}, resp_is_write, v.exp_is_write);
        check({tag, ".err"}, resp_err, v.exp_err);
        check({tag, ".resp_edge"}, rise_cyc, exp_edge);
        check({tag, ".resp_rises"}, rise_count - rise_base, 1);
        check({tag, ".clr_pulses"}, clr_count - clr_base, v.nrx);

        bad = 0;
        req_addr  = ~v.addr;
        req_valid = (v.hold > 0);
        for (int i = 0; i < v.hold; i++) begin
            step();
            if (!resp_valid || resp_rdata !== v.exp_rdata || resp_is_write !== v.exp_is_write ||
                resp_err !== v.exp_err || req_ready) bad++;
        end
        req_valid  = 1'b0;
        check({tag, ".hold_stable"}, bad, 0);
        check({tag, ".no_new_frame"}, tx_log.size() - tx_base, 4);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, ".resp_dropped"}, resp_valid, 0);
        check({tag, ".req_ready_after"}, req_ready, 1);
        check({tag, ".idle_after"}, busy, 0);
    endtask

    // Main sequence: reset state, table vectors, stale byte, mid-frame reset,
    // then randomized transactions.
    initial begin
        int s, ok, clr_base, tx_base;
        logic [7:0]  held_rdata;
        logic [31:0] r;
        vec_t v;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        req_is_write = 1'b0; resp_ready = 1'b0; uart_ready = 1'b0; uart_data_out = 8'h0;

        vecs[0] = mk(16'hA55A, 8'h3C, 1'b1, 2, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 0,  1'b0);
        vecs[1] = mk(16'h0102, 8'h5E, 1'b0, 2, 8'hC7, 8'h00, 8'hC7, 1'b0, 1'b0, 2,  1'b1);
        vecs[2] = mk(16'h1234, 8'h11, 1'b0, 2, 8'h11, 8'h01, 8'h11, 1'b1, 1'b1, 20, 1'b0);
        vecs[3] = mk(16'hFFFF, 8'hFF, 1'b1, 2, 8'hAB, 8'hFE, 8'hAB, 1'b0, 1'b1, 1,  1'b1);
        vecs[4] = mk(16'h0000, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 0,  1'b0);
        vecs[5] = mk(16'hBEEF, 8'h42, 1'b0, 1, 8'h99, 8'h00, 8'h00, 1'b0, 1'b1, 3,  1'b0);

        repeat (3) step();
        check("reset.req_ready", req_ready, 1);
        check("reset.resp_valid", resp_valid, 0);
        check("reset.wr_en", uart_wr_en, 0);
        check("reset.ready_clr", uart_ready_clr, 0);
        check("reset.busy", busy, 0);
        check("reset.rdata", resp_rdata, 0);
        check("reset.is_write", resp_is_write, 0);
        check("reset.err", resp_err, 0);
        check("reset.data_in", uart_data_in, 0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        held_rdata = resp_rdata;
        clr_base   = clr_count;
        send_rx(8'h77, s);
        repeat (10) step();
        check("stale.clr", clr_count - clr_base, 1);
        check("stale.resp_valid", resp_valid, 0);
        check("stale.busy", busy, 0);
        check("stale.rdata_kept", resp_rdata, held_rdata);

        tx_base = tx_log.size();
        req_addr = 16'h1357; req_wdata = 8'h9A; req_is_write = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_log.size() >= tx_base + 3) begin ok = 1; break; end
            step();
        end
        check("rst.reach_byte2", ok, 1);
        rst_n = 1'b0;
        step();
        check("rst.wr_en", uart_wr_en, 0);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.req_ready", req_ready, 1);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("rst.req_ready_release", req_ready, 1);
        check("rst.no_resume", tx_log.size() - tx_base, 3);
        run_txn(mk(16'h2468, 8'h5A, 1'b1, 2, 8'h5A, 8'h01, 8'h5A, 1'b1, 1'b0, 0, 1'b0), "rst.fresh");

        for (int n = 0; n < 30; n++) begin
            r = $urandom;
            v.addr     = r[15:0];
            v.wdata    = r[23:16];
            v.is_write = r[24];
            r = $urandom;
            v.rx0   = r[7:0];
            v.rx1   = r[15:8];
            if (r[19:16] < 4'd11) v.rx1[0] = v.is_write;
            v.nrx   = (r[23:20] == 4'd0) ? 0 : (r[23:20] == 4'd1) ? 1 : 2;
            v.hold  = int'(r[26:25]);
            v.stall = r[27];
            v.exp_rdata = 8'h00; v.exp_is_write = 1'b0; v.exp_err = 1'b0;
            v = model_fill(v);
            run_txn(v, $sformatf("rand%0d", n));
        end

        check("tx.wr_en_while_busy", wr_busy_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
